// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one operand bit per clock.
// Operands are accepted and results returned through valid/ready handshakes.
module bin2bcd_seq #(
    parameter int unsigned WIDTH  = 11,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  bin_q, bin_d;
    logic [BcdW-1:0]   bcd_q, bcd_d;
    logic              ovf_q, ovf_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [BcdW-1:0]   adj;

    // Add 3 to every digit >= 5 so the following doubling carries correctly into the next digit.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    bin_d   = bin_in;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CntW'(WIDTH);
                    state_d = StShift;
                end
            end
            StShift: begin
                // The bit leaving the top digit is worth 10^DIGITS; dropping it keeps the modulo.
                bcd_d = {adj[BcdW-2:0], bin_q[WIDTH-1]};
                ovf_d = ovf_q | adj[BcdW-1];
                bin_d = bin_q << 1;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            bin_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign bcd_out   = bcd_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: a 4-digit and a 3-digit instance, expected results queued by the
// stimulus and checked by an independent monitor whenever a result handshake occurs.
module tb_bin2bcd_seq;

    typedef struct packed {
        logic        dut;
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [10:0] bin       [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic        ovf       [2];
    logic [15:0] bcd4;
    logic [11:0] bcd3;
    logic [15:0] bcd       [2];

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    assign bcd[0] = bcd4;
    assign bcd[1] = {4'h0, bcd3};

    bin2bcd_seq #(.WIDTH(11), .DIGITS(4)) u_dut4 (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid[0]),
        .in_ready (in_ready[0]),
        .bin_in   (bin[0]),
        .out_valid(out_valid[0]),
        .out_ready(out_ready[0]),
        .bcd_out  (bcd4),
        .overflow (ovf[0])
    );

    bin2bcd_seq #(.WIDTH(11), .DIGITS(3)) u_dut3 (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid[1]),
        .in_ready (in_ready[1]),
        .bin_in   (bin[1]),
        .out_valid(out_valid[1]),
        .out_ready(out_ready[1]),
        .bcd_out  (bcd3),
        .overflow (ovf[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    // Monitor: a result is consumed on the next rising edge when valid and ready are both high.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (out_valid[k] && out_ready[k]) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_result dut%0d: got bcd=%h ovf=%b, required no result",
                             k, bcd[k], ovf[k]);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.dut != k[0] || bcd[k] !== e.bcd || ovf[k] !== e.ovf) begin
                        n_fail++;
                        $display("FAIL result dut%0d: got bcd=%h ovf=%b, required dut%0d bcd=%h ovf=%b",
                                 k, bcd[k], ovf[k], e.dut, e.bcd, e.ovf);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while (!in_ready[k] && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready[k]) check("idle_timeout", 32'(in_ready[k]), 32'd1);
    endtask

    task automatic conv(input int k, input int v, input logic [15:0] eb, input logic eo);
        exp_t e;
        e.dut = k[0];
        e.bcd = eb;
        e.ovf = eo;
        exp_q.push_back(e);
        out_ready[k] = 1'b1;
        wait_idle(k);
        in_valid[k] = 1'b1;
        bin[k]      = 11'(v);
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        bin[k]      = 11'($urandom);
        wait_idle(k);
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r = '0;
        int          x = v;
        for (int d = 0; d < 4; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    initial begin
        int lat;
        for (int k = 0; k < 2; k++) begin
            in_valid[k]  = 1'b0;
            bin[k]       = '0;
            out_ready[k] = 1'b0;
        end
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset then idle.
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                check("reset_idle", {13'd0, in_ready[k], out_valid[k], ovf[k], bcd[k]},
                      {13'd0, 1'b1, 1'b0, 1'b0, 16'h0000});
            end
        end

        // Full-scale value with latency and return-to-idle timing.
        exp_q.push_back('{dut: 1'b0, bcd: 16'h2047, ovf: 1'b0});
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        bin[0]       = 11'd2047;
        @(posedge clk); #1;
        in_valid[0]  = 1'b0;
        lat = 0;
        while (!out_valid[0] && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'd11);
        @(posedge clk); #1;
        check("back_to_idle", {30'd0, in_ready[0], out_valid[0]}, 32'b10);

        // Digit sweep.
        conv(0, 0,    16'h0000, 1'b0);
        conv(0, 9,    16'h0009, 1'b0);
        conv(0, 10,   16'h0010, 1'b0);
        conv(0, 99,   16'h0099, 1'b0);
        conv(0, 100,  16'h0100, 1'b0);
        conv(0, 1999, 16'h1999, 1'b0);
        conv(0, 1000, 16'h1000, 1'b0);
        for (int v = 0; v < 2048; v++) conv(0, v, ref_bcd(v), 1'b0);

        // Overflow on the 3-digit instance, then sticky flag cleared on the next accept.
        conv(1, 2047, 16'h0047, 1'b1);
        conv(1, 999,  16'h0999, 1'b0);

        // Backpressure with ignored operands.
        exp_q.push_back('{dut: 1'b0, bcd: 16'h1500, ovf: 1'b0});
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        bin[0]       = 11'd1500;
        @(posedge clk); #1;
        in_valid[0]  = 1'b0;
        lat = 0;
        while (!out_valid[0] && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        check("stall_reach_done", 32'(out_valid[0]), 32'd1);
        for (int c = 0; c < 15; c++) begin
            in_valid[0] = c[0];
            bin[0]      = 11'($urandom);
            @(posedge clk); #1;
            check("stall_hold", {13'd0, in_ready[0], out_valid[0], ovf[0], bcd[0]},
                  {13'd0, 1'b0, 1'b1, 1'b0, 16'h1500});
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        wait_idle(0);
        repeat (20) @(posedge clk);
        #1;
        check("no_extra_result", {30'd0, in_ready[0], out_valid[0]}, 32'b10);

        // Reset mid-operation.
        in_valid[0] = 1'b1;
        bin[0]      = 11'd1234;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("mid_reset", {13'd0, in_ready[0], out_valid[0], ovf[0], bcd[0]},
              {13'd0, 1'b1, 1'b0, 1'b0, 16'h0000});
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        conv(0, 567, 16'h0567, 1'b0);

        repeat (5) @(posedge clk);
        check("pending_results", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Parametrised, sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It processes one binary bit per clock. Operands arrive and results leave through valid/ready handshakes. It sits between binary arithmetic/counter logic and the seven-segment display drivers. It replaces fixed-width combinational converters in designs where area matters more than latency. It also reports when the requested digit count cannot hold the value.

## Interface

Parameters:
- `WIDTH`, default 11: binary operand width; legal range 1..32.
- `DIGITS`, default 4: number of BCD digits produced; legal range 1..10.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `reset_n`, input, 1: reset is asynchronous and active-low.
- `in_valid`, input, 1: `bin_in` holds an operand.
- `in_ready`, output, 1: converter can accept an operand; high exactly when the state is IDLE.
- `bin_in`, input, `WIDTH`: unsigned binary operand.
- `out_valid`, output, 1: `bcd_out` and `overflow` hold a finished result.
- `out_ready`, input, 1: consumer accepts the result.
- `bcd_out`, output, 4*`DIGITS`: packed BCD; digit 0 (ones) sits at bits [3:0].
- `overflow`, output, 1: the value did not fit in `DIGITS` digits.

## Operation

- State machine: IDLE → SHIFT → DONE → IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: latch `bin_in` into the shift register, clear the BCD accumulator and sticky overflow, load the bit counter with `WIDTH`, then go to SHIFT.
- SHIFT: each cycle performs one iteration:
  - Every 4-bit digit whose value is ≥5 gets +3, all digits in parallel.
  - Then the concatenation {accumulator, operand} shifts left by one bit, with the operand MSB entering digit 0 LSB.
  - The counter decrements by one.
  - When the counter reaches 0 after the shift, go to DONE.
- Overflow: a 1 shifted out of the top digit's MSB during any iteration sets the sticky `overflow`.
  - On overflow, `bcd_out` equals the true value modulo 10^`DIGITS`.
- DONE:
  - `out_valid`=1; `bcd_out` and `overflow` are held stable.
  - On `out_valid`&`out_ready`: go to IDLE.
  - The result registers keep their last value after leaving DONE. They are only valid while `out_valid`=1.
- Each digit stays within 0..9 at every completed iteration. No digit ever leaves the register in the range 10..15.
- Input handshake rules:
  - `in_valid` asserted outside IDLE is ignored; the operand is not latched.
  - `bin_in` is sampled only on the accept edge; changes afterwards have no effect.
- Output handshake rules:
  - `out_ready` asserted outside DONE has no effect.
  - `out_ready` held low in DONE stalls the block indefinitely, with `in_ready`=0.
- Reset (asynchronous):
  - Forces IDLE; `out_valid`=0, `bcd_out`=0, `overflow`=0, counter=0, and the operand register=0.
  - `in_ready`=1 once the state is IDLE.
  - Reset during SHIFT or DONE discards the operation with no partial result and no `out_valid` pulse.

## Timing

- Accept edge E0: the operand is latched.
- Edges E1..E`WIDTH`: one iteration per edge.
- After edge E`WIDTH`: `out_valid`=1, so latency is `WIDTH` cycles from the accept edge.
- If `out_ready`=1 during the first DONE cycle, the block is back in IDLE one edge later.
- Best-case throughput: one conversion per `WIDTH`+2 cycles.
- There is no combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.
- All outputs are registered or decoded from state only.

## Test plan

- Reset then idle, `WIDTH`=11, `DIGITS`=4:
  - Stimulus: assert `reset_n`=0, release it, and hold `in_valid`=0.
  - Required: `in_ready`=1, `out_valid`=0, `bcd_out`=0x0000 and `overflow`=0 for 20 cycles.
- Full-scale value, `WIDTH`=11, `DIGITS`=4:
  - Stimulus: present `bin_in`=2047 with `out_ready`=1.
  - Required: `out_valid` rises exactly 11 edges after acceptance with `bcd_out`=0x2047 and `overflow`=0.
  - Required: the block is back in IDLE one edge later.
- Digit sweep, `WIDTH`=11, `DIGITS`=4:
  - Stimulus: convert 0, 9, 10, 99, 100, 1999 and 1000.
  - Required: `bcd_out`=0x0000, 0x0009, 0x0010, 0x0099, 0x0100, 0x1999 and 0x1000 respectively.
  - Required: `overflow`=0 in every case.
  - Required: an exhaustive 0..2047 sweep matches the decimal reference.
- Overflow, `WIDTH`=11, `DIGITS`=3:
  - Stimulus: convert 2047.
  - Required: `bcd_out`=0x047 and `overflow`=1.
  - Stimulus: convert 999 next.
  - Required: `bcd_out`=0x999 and `overflow`=0, showing the sticky flag cleared on accept.
- Backpressure and ignored input:
  - Stimulus: hold `out_ready`=0 for 15 cycles in DONE, toggling `in_valid` and `bin_in` meanwhile.
  - Required: `in_ready`=0, and `bcd_out` and `overflow` stay stable.
  - Required: the extra operand is never converted; one handshake yields exactly one result.
- Reset mid-operation:
  - Stimulus: after accepting 1234, assert `reset_n`=0 at iteration 5.
  - Required: all outputs return to their reset values immediately, with no `out_valid` pulse.
  - Stimulus: convert 567 after reset.
  - Required: `bcd_out`=0x0567.
